conv_sys_array: RTL and testbench

- Parametrised streaming KxK convolution engine, successor to the fixed 3x3 systolic array feeding the pooling stage.
- Holds a serially loaded KxK weight set and accepts an IMGxIMG feature map as a row-major pixel stream with a valid/ready handshake.
- Emits (IMG-K+1)^2 valid-window results with fixed-point rounding, saturation and optional ReLU6, then pulses done.

---
 rtl/conv_sys_array_if.sv | 63 ++++++
 rtl/conv_sys_array.sv | 271 +++++++++++++++++++++++++++
 tb/tb_conv_sys_array.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_sys_array_if.sv
// ---------------------------------------------------------------------------
// conv_sys_array_if
//
// Purpose: groups the control, weight-load, pixel-stream and result signals
// of conv_sys_array so that the engine and its driver connect through one
// bundle. clk and rst_n stay outside as plain ports of the engine.
//
// Handshake rules:
//   - Pixel stream: a beat transfers on a rising edge where px_valid and
//     px_ready are both 1. px_ready only ever rises in RUN. px_valid is
//     ignored while px_ready is 0.
//   - Weight load: each w_load=1 edge (in IDLE or LOAD_W) stores one weight.
//     There is no ready; the engine always takes the beat in those states.
//   - Results: out_valid marks one result per cycle with no backpressure.
//
// Signals (direction seen from the engine, i.e. the slave modport):
//   clear     in   soft abort back to IDLE
//   w_load    in   weight beat valid
//   w_data    in   signed weight, row-major
//   start     in   one-cycle map start pulse
//   px_valid  in   pixel beat valid
//   px_data   in   signed pixel, row-major
//   px_ready  out  pixel beat accepted when px_valid & px_ready
//   out_valid out  result valid
//   out_data  out  signed result
//   out_last  out  final result of a map
//   busy      out  high in RUN and DRAIN
//   done      out  one-cycle map-complete pulse
//   wts_ok    out  full weight set loaded
//   state_dbg out  current FSM state encoding, for observation only
// ---------------------------------------------------------------------------
interface conv_sys_array_if #(
    parameter int DW = 16
);
    logic          clear;
    logic          w_load;
    logic [DW-1:0] w_data;
    logic          start;
    logic          px_valid;
    logic [DW-1:0] px_data;
    logic          px_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          wts_ok;
    logic [2:0]    state_dbg;

    // Driver side (testbench or upstream block).
    modport master (
        output clear, w_load, w_data, start, px_valid, px_data,
        input  px_ready, out_valid, out_data, out_last, busy, done, wts_ok,
               state_dbg
    );

    // Engine side.
    modport slave (
        input  clear, w_load, w_data, start, px_valid, px_data,
        output px_ready, out_valid, out_data, out_last, busy, done, wts_ok,
               state_dbg
    );
endinterface

// File: rtl/conv_sys_array.sv
// ---------------------------------------------------------------------------
// conv_sys_array
//
// Purpose: streaming KxK convolution over an IMGxIMG feature map. A KxK
// weight set is loaded serially and persists across maps. Each map arrives
// as a row-major pixel stream; every valid window (no padding) produces one
// fixed-point result, rounded toward -inf by FRAC bits, saturated to DW bits
// and optionally clamped to [0, 6.0] (ReLU6).
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous reset, ACTIVE HIGH despite the name (kept for
//          compatibility with the block this replaces)
//   bus    conv_sys_array_if.slave: control, weights, pixels, results
//
// Pipeline per result:
//   edge E   : completing pixel accepted, window register updated
//   edge E+1 : stage 1, K*K full-width products registered
//   edge E+2 : stage 2, adder tree + shift/saturate/ReLU6 registered,
//              out_valid high
// ---------------------------------------------------------------------------
module conv_sys_array #(
    parameter int K        = 3,
    parameter int IMG      = 7,
    parameter int DW       = 16,
    parameter int FRAC     = 8,
    parameter int RELU6_EN = 1
) (
    input logic              clk,
    input logic              rst_n,
    conv_sys_array_if.slave  bus
);

    localparam int NW  = K * K;
    localparam int WIW = $clog2(NW);
    localparam int CW  = $clog2(IMG);
    localparam int PW  = 2 * DW;
    localparam int AW  = 2 * DW + $clog2(NW);

    localparam logic [CW-1:0]  LAST_POS = CW'(IMG - 1);
    localparam logic [CW-1:0]  FIRST_WIN = CW'(K - 1);
    localparam logic [WIW-1:0] LAST_W   = WIW'(NW - 1);

    localparam logic signed [AW-1:0] SAT_MAX = (AW'(1) <<< (DW - 1)) - AW'(1);
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic signed [AW-1:0] R6_MAX  = AW'(6) <<< FRAC;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                 state;
    logic signed [DW-1:0]   w_q [NW];
    logic [WIW-1:0]         w_idx;
    logic                   wts_ok_q;
    logic                   px_ready_q;
    logic                   busy_q;
    logic                   done_q;

    logic [CW-1:0]          row;
    logic [CW-1:0]          col;
    logic [DW-1:0]          lb  [K-1][IMG];   // lb[0] holds the oldest row
    logic signed [DW-1:0]   win [NW];         // win[i*K+j], row i, column j
    logic                   v0, last0;        // window complete this cycle
    logic signed [PW-1:0]   prod [NW];
    logic                   v1, last1;        // products valid
    logic                   out_valid_q;
    logic                   out_last_q;
    logic [DW-1:0]          out_data_q;

    logic                   accept;
    logic                   last_px;

    logic signed [AW-1:0]   acc;
    logic signed [AW-1:0]   shd;
    logic signed [AW-1:0]   clamped;
    logic [DW-1:0]          post;

    assign accept  = bus.px_valid & px_ready_q;
    assign last_px = accept && (row == LAST_POS) && (col == LAST_POS);

    // ------------------------------------------------------------------
    // Control FSM: state, weight store, handshake/status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= S_IDLE;
            w_idx      <= '0;
            wts_ok_q   <= 1'b0;
            px_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < NW; i++) begin
                w_q[i] <= '0;
            end
        end else if (bus.clear) begin
            // Weights survive an abort; a half-loaded set does not count.
            state      <= S_IDLE;
            w_idx      <= '0;
            px_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            if (state == S_LOAD_W) begin
                wts_ok_q <= 1'b0;
            end
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    // w_load takes priority over start.
                    if (bus.w_load) begin
                        w_q[0]   <= bus.w_data;
                        w_idx    <= WIW'(1);
                        wts_ok_q <= 1'b0;
                        state    <= S_LOAD_W;
                    end else if (bus.start && wts_ok_q) begin
                        px_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state      <= S_RUN;
                    end
                end
                S_LOAD_W: begin
                    if (bus.w_load) begin
                        w_q[w_idx] <= bus.w_data;
                        if (w_idx == LAST_W) begin
                            w_idx    <= '0;
                            wts_ok_q <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            w_idx <= w_idx + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (last_px) begin
                        px_ready_q <= 1'b0;
                        state      <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // out_last is on the outputs now; done follows one cycle later.
                    if (out_last_q) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: adder tree and post-processing
    // ------------------------------------------------------------------
    always_comb begin
        acc = '0;
        for (int i = 0; i < NW; i++) begin
            acc = acc + AW'(prod[i]);
        end
        shd     = acc >>> FRAC;
        clamped = shd;
        if (shd > SAT_MAX) begin
            clamped = SAT_MAX;
        end else if (shd < SAT_MIN) begin
            clamped = SAT_MIN;
        end
        if (RELU6_EN != 0) begin
            if (clamped[AW-1]) begin
                clamped = '0;
            end else if (clamped > R6_MAX) begin
                clamped = R6_MAX;
            end
        end
        post = DW'(clamped);
    end

    // ------------------------------------------------------------------
    // Datapath: position counters, line buffer, window, pipeline stages
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n || bus.clear) begin
            row         <= '0;
            col         <= '0;
            v0          <= 1'b0;
            last0       <= 1'b0;
            v1          <= 1'b0;
            last1       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < K - 1; i++) begin
                for (int c = 0; c < IMG; c++) begin
                    lb[i][c] <= '0;
                end
            end
            for (int i = 0; i < NW; i++) begin
                win[i]  <= '0;
                prod[i] <= '0;
            end
        end else begin
            if (accept) begin
                // Counters wrap to (0,0) after the final pixel, ready for the next map.
                if (col == LAST_POS) begin
                    col <= '0;
                    row <= (row == LAST_POS) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end

                // Window slides one column left; the new right column is the
                // column-`col` slice of the K-1 buffered rows plus the new pixel.
                for (int i = 0; i < K; i++) begin
                    for (int j = 0; j < K - 1; j++) begin
                        win[i*K+j] <= win[i*K+j+1];
                    end
                end
                for (int i = 0; i < K - 1; i++) begin
                    win[i*K+K-1] <= lb[i][col];
                end
                win[NW-1] <= bus.px_data;

                // Column `col` of the line buffer ages by one row.
                for (int i = 0; i < K - 2; i++) begin
                    lb[i][col] <= lb[i+1][col];
                end
                lb[K-2][col] <= bus.px_data;
            end

            // The window is a real (unpadded) window only once K-1 full rows
            // and K-1 columns of the current row have been seen.
            v0    <= accept && (row >= FIRST_WIN) && (col >= FIRST_WIN);
            last0 <= last_px;

            for (int i = 0; i < NW; i++) begin
                prod[i] <= PW'(w_q[i]) * PW'(win[i]);
            end
            v1    <= v0;
            last1 <= last0;

            out_valid_q <= v1;
            out_last_q  <= last1;
            out_data_q  <= v1 ? post : '0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.px_ready  = px_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.wts_ok    = wts_ok_q;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_conv_sys_array.sv
// ---------------------------------------------------------------------------
// tb_conv_sys_array
//
// Two engines (RELU6_EN=1 and RELU6_EN=0) share one input stream, so each
// directed map checks the clamped and the saturation-only result together.
// ---------------------------------------------------------------------------
module tb_conv_sys_array;

    localparam int DW   = 16;
    localparam int NPX  = 49;
    localparam int NOUT = 25;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_W = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    conv_sys_array_if #(.DW(DW)) b1 ();
    conv_sys_array_if #(.DW(DW)) b0 ();

    assign b0.clear    = b1.clear;
    assign b0.w_load   = b1.w_load;
    assign b0.w_data   = b1.w_data;
    assign b0.start    = b1.start;
    assign b0.px_valid = b1.px_valid;
    assign b0.px_data  = b1.px_data;

    conv_sys_array #(.K(3), .IMG(7), .DW(DW), .FRAC(8), .RELU6_EN(1)) u_relu (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1.slave)
    );

    conv_sys_array #(.K(3), .IMG(7), .DW(DW), .FRAC(8), .RELU6_EN(0)) u_raw (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0.slave)
    );

    // ---------------- scoreboard ----------------
    int n_assert = 0;
    int n_fail   = 0;

    logic [DW-1:0] exp1_q[$];
    logic [DW-1:0] exp0_q[$];
    logic [DW-1:0] got1[$];
    logic [DW-1:0] got0[$];
    int out_cyc1[$];
    int last_pos1[$];
    int last_pos0[$];
    int last_cyc1[$];
    int done_cyc1[$];
    int done_cnt0 = 0;

    int base1, base0, lbase1, lbase0, dbase1, dbase0;
    int acc16;
    logic [DW-1:0] px_mem [NPX];

    // Output monitor: samples 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        if (b1.out_valid) begin
            if (b1.out_last) begin
                last_pos1.push_back(got1.size());
                last_cyc1.push_back(cyc);
            end
            got1.push_back(b1.out_data);
            out_cyc1.push_back(cyc);
        end
        if (b0.out_valid) begin
            if (b0.out_last) last_pos0.push_back(got0.size());
            got0.push_back(b0.out_data);
        end
        if (b1.done) done_cyc1.push_back(cyc);
        if (b0.done) done_cnt0++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_quiet(input string tag, input logic [DW-1:0] wts);
        check({tag, "_out_valid"}, b1.out_valid, 0);
        check({tag, "_out_data"},  b1.out_data,  0);
        check({tag, "_out_last"},  b1.out_last,  0);
        check({tag, "_px_ready"},  b1.px_ready,  0);
        check({tag, "_busy"},      b1.busy,      0);
        check({tag, "_done"},      b1.done,      0);
        check({tag, "_wts_ok"},    b1.wts_ok,    wts);
        check({tag, "_state"},     b1.state_dbg, ST_IDLE);
        check({tag, "_raw_valid"}, b0.out_valid, 0);
    endtask

    // Loads 9 weights; kind 0: all w, kind 1: identity (centre 1.0).
    // The first beat also raises start to show w_load wins.
    task automatic load_w(input string tag, input logic [DW-1:0] w, input bit ident, input bit gaps);
        for (int k = 0; k < 9; k++) begin
            b1.w_data = ident ? ((k == 4) ? 16'h0100 : 16'h0000) : w;
            b1.w_load = 1'b1;
            b1.start  = (k == 0);
            @(negedge clk);
            b1.w_load = 1'b0;
            b1.start  = 1'b0;
            if (k == 0) begin
                check({tag, "_ld_state"}, b1.state_dbg, ST_LOAD_W);
                check({tag, "_ld_wts_ok"}, b1.wts_ok, 0);
            end
            if (gaps) @(negedge clk);
        end
        check({tag, "_wts_ok"}, b1.wts_ok, 1);
        check({tag, "_ld_done_state"}, b1.state_dbg, ST_IDLE);
    endtask

    task automatic start_map(input string tag);
        b1.start = 1'b1;
        @(negedge clk);
        b1.start = 1'b0;
        check({tag, "_run_state"}, b1.state_dbg, ST_RUN);
        check({tag, "_run_ready"}, b1.px_ready, 1);
        check({tag, "_run_busy"},  b1.busy, 1);
    endtask

    task automatic send_px(input string tag, input int npx, input bit gap);
        int t;
        for (int n = 0; n < npx; n++) begin
            if (gap && n > 0) begin
                b1.px_valid = 1'b0;
                @(negedge clk);
                check($sformatf("%s_gap_ready%0d", tag, n), b1.px_ready, 1);
            end
            b1.px_valid = 1'b1;
            b1.px_data  = px_mem[n];
            t = 0;
            while (!b1.px_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (t == 20) check($sformatf("%s_ready_timeout%0d", tag, n), 0, 1);
            if (n == 16) acc16 = cyc + 1;
            @(negedge clk);
        end
        b1.px_valid = 1'b0;
    endtask

    task automatic mark();
        base1  = got1.size();
        base0  = got0.size();
        lbase1 = last_pos1.size();
        lbase0 = last_pos0.size();
        dbase1 = done_cyc1.size();
        dbase0 = done_cnt0;
    endtask

    task automatic fill_const(input logic [DW-1:0] e1, input logic [DW-1:0] e0);
        exp1_q.delete();
        exp0_q.delete();
        for (int k = 0; k < NOUT; k++) begin
            exp1_q.push_back(e1);
            exp0_q.push_back(e0);
        end
    endtask

    // Identity kernel picks the centre pixel px[r+1][c+1] = (r+1)*7 + (c+1).
    task automatic fill_ident();
        exp1_q.delete();
        exp0_q.delete();
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                exp1_q.push_back(16'((r + 1) * 7 + c + 1));
                exp0_q.push_back(16'((r + 1) * 7 + c + 1));
            end
        end
    endtask

    task automatic check_map(input string tag);
        check({tag, "_n_relu"}, got1.size() - base1, NOUT);
        check({tag, "_n_raw"},  got0.size() - base0, NOUT);
        for (int k = 0; k < NOUT; k++) begin
            if (base1 + k < got1.size())
                check($sformatf("%s_relu%0d", tag, k), got1[base1+k], exp1_q[k]);
            if (base0 + k < got0.size())
                check($sformatf("%s_raw%0d", tag, k), got0[base0+k], exp0_q[k]);
        end
        check({tag, "_nlast_relu"}, last_pos1.size() - lbase1, 1);
        check({tag, "_nlast_raw"},  last_pos0.size() - lbase0, 1);
        if (last_pos1.size() > lbase1)
            check({tag, "_last_pos"}, last_pos1[lbase1], base1 + NOUT - 1);
        if (last_pos0.size() > lbase0)
            check({tag, "_last_pos_raw"}, last_pos0[lbase0], base0 + NOUT - 1);
        check({tag, "_ndone"},     done_cyc1.size() - dbase1, 1);
        check({tag, "_ndone_raw"}, done_cnt0 - dbase0, 1);
        if (done_cyc1.size() > dbase1 && last_cyc1.size() > lbase1)
            check({tag, "_done_after_last"}, done_cyc1[dbase1] - last_cyc1[lbase1], 1);
        check_quiet({tag, "_end"}, 1);
    endtask

    task automatic run_map(input string tag, input bit gap);
        mark();
        start_map(tag);
        send_px(tag, NPX, gap);
        check({tag, "_drain_ready"}, b1.px_ready, 0);
        check({tag, "_drain_state"}, b1.state_dbg, ST_DRAIN);
        check({tag, "_drain_busy"},  b1.busy, 1);
        tick(6);
        check_map(tag);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int sz1, sz0, nd;
        b1.clear    = 1'b0;
        b1.w_load   = 1'b0;
        b1.w_data   = '0;
        b1.start    = 1'b0;
        b1.px_valid = 1'b0;
        b1.px_data  = '0;
        rst_n       = 1'b1;
        acc16       = 0;
        tick(3);
        check_quiet("reset", 0);
        rst_n = 1'b0;
        tick(1);

        // start without weights is ignored
        b1.start = 1'b1;
        tick(1);
        b1.start = 1'b0;
        tick(1);
        check_quiet("nowts_start", 0);

        // all 1.0 weights, all 1.0 pixels: 9.0 -> 6.0 clamped / 9.0 raw
        load_w("ones", 16'h0100, 1'b0, 1'b1);
        for (int n = 0; n < NPX; n++) px_mem[n] = 16'h0100;
        fill_const(16'h0600, 16'h0900);
        run_map("ones", 1'b0);

        // all -1.0 weights: -9.0 -> 0 clamped / 0xF700 raw
        load_w("neg", 16'hFF00, 1'b0, 1'b0);
        fill_const(16'h0000, 16'hF700);
        run_map("neg", 1'b0);

        // identity kernel, raw pixel ramp
        load_w("ident", 16'h0000, 1'b1, 1'b0);
        for (int n = 0; n < NPX; n++) px_mem[n] = 16'(n);
        fill_ident();
        run_map("ident", 1'b0);
        if (out_cyc1.size() > base1)
            check("ident_latency", out_cyc1[base1] - acc16, 2);

        // same weights, start only, px_valid every other cycle
        run_map("ident_gap", 1'b1);
        if (out_cyc1.size() > base1)
            check("gap_latency", out_cyc1[base1] - acc16, 2);

        // positive saturation
        load_w("satp", 16'h7FFF, 1'b0, 1'b0);
        for (int n = 0; n < NPX; n++) px_mem[n] = 16'h7FFF;
        fill_const(16'h0600, 16'h7FFF);
        run_map("satp", 1'b0);

        // negative saturation
        load_w("satn", 16'h8000, 1'b0, 1'b0);
        fill_const(16'h0000, 16'h8000);
        run_map("satn", 1'b0);

        // clear after 20 pixels, then a complete map
        load_w("clr", 16'h0000, 1'b1, 1'b0);
        for (int n = 0; n < NPX; n++) px_mem[n] = 16'(n);
        start_map("clr");
        send_px("clr", 20, 1'b0);
        nd  = done_cyc1.size();
        b1.clear = 1'b1;
        sz1 = got1.size();
        sz0 = got0.size();
        tick(1);
        b1.clear = 1'b0;
        tick(8);
        check("clr_no_out_relu", got1.size(), sz1);
        check("clr_no_out_raw",  got0.size(), sz0);
        check("clr_no_done",     done_cyc1.size(), nd);
        check_quiet("clr_idle", 1);
        fill_ident();
        run_map("clr_rerun", 1'b0);

        // reset in the middle of a map
        start_map("mrst");
        send_px("mrst", 10, 1'b0);
        rst_n = 1'b1;
        tick(1);
        rst_n = 1'b0;
        check_quiet("mrst", 0);
        sz1 = got1.size();
        b1.start = 1'b1;
        tick(1);
        b1.start = 1'b0;
        tick(4);
        check_quiet("mrst_start_ignored", 0);
        check("mrst_no_out", got1.size(), sz1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
